// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants and state encoding for the LC-3 memory bus controller
package mem_bus_pkg;

    localparam int          DATA_W      = 16;
    localparam int          SRAM_AW_DEF = 20;
    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_W_PULSE = 2'd1;
    localparam state_t ST_W_HOLD  = 2'd2;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - control-unit side of the memory bus (strobes, MAR, MDR, read data)
interface mem_bus_ctrl_if;
    import mem_bus_pkg::*;

    logic              Mem_CE;
    logic              Mem_OE;
    logic              Mem_WE;
    logic [DATA_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_from_CPU;
    logic [DATA_W-1:0] Data_to_CPU;

    modport master (
        output Mem_CE, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
        input  Data_to_CPU
    );

    modport slave (
        input  Mem_CE, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
        output Data_to_CPU
    );
endinterface

// File: rtl/mem_bus_ctrl_io_regs.sv
// rtl/mem_bus_ctrl_io_regs.sv - HEX display register and the Switches/SRAM read-data mux
module io_regs
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              io_hit,
    input  logic [DATA_W-1:0] switches,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic [DATA_W-1:0] data_to_cpu,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] hex_data
);

    always_comb begin
        data_to_cpu = '0;
        if (rd_en)
            data_to_cpu = io_hit ? switches : sram_dq_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            hex_data <= '0;
        else if (wr_en)
            hex_data <= wr_data;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - LC-3 strobe to async SRAM sequencer with one memory-mapped I/O word
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEF,
    parameter int          SRAM_AW = SRAM_AW_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_bus_ctrl_if.slave      cpu,
    input  logic [DATA_W-1:0]  Switches,
    output logic [DATA_W-1:0]  HEX_Data,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    input  logic [DATA_W-1:0]  SRAM_DQ_in,
    output logic [DATA_W-1:0]  SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    output logic               Access_Err,
    output logic [DATA_W-1:0]  Wr_Count
);

    state_t            state;
    state_t            state_next;
    logic              we_prev;
    logic              io_hit_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_data;

    logic in_idle, in_pulse, in_hold, in_wr;
    logic ce, oe_req, we_req, io_hit_now;
    logic wr_start, rd_req, pulse_ok, short_wr, viol;

    assign in_idle    = (state == ST_IDLE);
    assign in_pulse   = (state == ST_W_PULSE);
    assign in_hold    = (state == ST_W_HOLD);
    assign in_wr      = in_pulse | in_hold;

    assign ce         = ~cpu.Mem_CE;
    assign oe_req     = ~cpu.Mem_OE;
    assign we_req     = ~cpu.Mem_WE;
    assign io_hit_now = (cpu.ADDR == IO_ADDR);

    // we_prev makes a write start only on the falling edge of Mem_WE
    assign wr_start = in_idle & ce & we_req & we_prev & ~oe_req;
    assign rd_req   = in_idle & ce & oe_req & ~we_req;
    assign pulse_ok = in_pulse & we_req;
    assign short_wr = in_pulse & ~we_req;
    assign viol     = (ce & oe_req & we_req) | (ce & oe_req & in_wr) | short_wr;

    // Address/data come live in IDLE so they settle a full cycle before WE_N drops
    assign SRAM_ADDR   = in_idle ? SRAM_AW'(cpu.ADDR) : SRAM_AW'(addr_q);
    assign SRAM_DQ_out = in_idle ? cpu.Data_from_CPU : data_q;
    assign SRAM_DQ_oe  = (wr_start & ~io_hit_now) | (in_wr & ~io_hit_q);
    assign SRAM_WE_N   = ~(pulse_ok & ~io_hit_q);
    assign SRAM_OE_N   = ~(rd_req & ~io_hit_now);
    assign SRAM_CE_N   = cpu.Mem_CE;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (wr_start) state_next = ST_W_PULSE;
            ST_W_PULSE: state_next = pulse_ok ? ST_W_HOLD : ST_IDLE;
            ST_W_HOLD:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            we_prev    <= 1'b1;
            io_hit_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            Wr_Count   <= '0;
            Access_Err <= 1'b0;
        end else begin
            state   <= state_next;
            we_prev <= cpu.Mem_WE;
            if (wr_start) begin
                addr_q   <= cpu.ADDR;
                data_q   <= cpu.Data_from_CPU;
                io_hit_q <= io_hit_now;
            end
            if (pulse_ok)
                Wr_Count <= Wr_Count + 16'd1;
            if (viol)
                Access_Err <= 1'b1;
        end
    end

    io_regs u_io_regs (
        .clk         (Clk),
        .reset       (Reset),
        .rd_en       (rd_req),
        .io_hit      (io_hit_now),
        .switches    (Switches),
        .sram_dq_in  (SRAM_DQ_in),
        .data_to_cpu (rd_data),
        .wr_en       (pulse_ok & io_hit_q),
        .wr_data     (data_q),
        .hex_data    (HEX_Data)
    );

    assign cpu.Data_to_CPU = rd_data;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - directed and randomized checks of mem_bus_ctrl against a transaction-level model
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switches, hex_data, sram_dq_in, sram_dq_out, wr_count;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, access_err;

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl #(.IO_ADDR(16'hFFFF), .SRAM_AW(20)) dut (
        .Clk         (clk),
        .Reset       (rst),
        .cpu         (bus),
        .Switches    (switches),
        .HEX_Data    (hex_data),
        .SRAM_ADDR   (sram_addr),
        .SRAM_CE_N   (sram_ce_n),
        .SRAM_OE_N   (sram_oe_n),
        .SRAM_WE_N   (sram_we_n),
        .SRAM_DQ_in  (sram_dq_in),
        .SRAM_DQ_out (sram_dq_out),
        .SRAM_DQ_oe  (sram_dq_oe),
        .Access_Err  (access_err),
        .Wr_Count    (wr_count)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] m_hex;
    logic [15:0] m_cnt;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic ce, input logic oe, input logic we);
        bus.Mem_CE = ce;
        bus.Mem_OE = oe;
        bus.Mem_WE = we;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_err"}, 32'(access_err), 32'(m_err));
        chk({tag, "_cnt"}, 32'(wr_count), 32'(m_cnt));
        chk({tag, "_hex"}, 32'(hex_data), 32'(m_hex));
    endtask

    task automatic model_reset();
        m_hex = '0;
        m_cnt = '0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        set_bus(1, 1, 1);
        cyc();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_status("rst");
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    endtask

    // Full three-cycle write: the SRAM sees WE_N low only in the middle cycle.
    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        logic io;
        io = (addr == 16'hFFFF);
        cyc();
        set_bus(0, 1, 0);
        bus.ADDR = addr;
        bus.Data_from_CPU = data;
        @(negedge clk);
        chk("wn_we_n", 32'(sram_we_n), 32'd1);
        chk("wn_dq_oe", 32'(sram_dq_oe), 32'(!io));
        chk("wn_addr", 32'(sram_addr), 32'(addr));
        chk("wn_rd0", 32'(bus.Data_to_CPU), 32'd0);
        if (!io) chk("wn_dq", 32'(sram_dq_out), 32'(data));
        cyc();
        bus.ADDR = 16'($urandom);
        bus.Data_from_CPU = 16'($urandom);
        @(negedge clk);
        chk("wp_we_n", 32'(sram_we_n), 32'(io));
        chk("wp_dq_oe", 32'(sram_dq_oe), 32'(!io));
        chk("wp_addr", 32'(sram_addr), 32'(addr));
        if (!io) chk("wp_dq", 32'(sram_dq_out), 32'(data));
        m_cnt = m_cnt + 16'd1;
        if (io) m_hex = data;
        cyc();
        set_bus(1, 1, 1);
        @(negedge clk);
        chk("wh_we_n", 32'(sram_we_n), 32'd1);
        chk("wh_dq_oe", 32'(sram_dq_oe), 32'(!io));
        if (!io) chk("wh_dq", 32'(sram_dq_out), 32'(data));
        chk_status("wh");
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [15:0] dq, input logic [15:0] sw, input int ncyc);
        logic io;
        io = (addr == 16'hFFFF);
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            set_bus(0, 0, 1);
            bus.ADDR = addr;
            sram_dq_in = dq;
            switches = sw;
            @(negedge clk);
            chk("rd_oe_n", 32'(sram_oe_n), 32'(io));
            chk("rd_we_n", 32'(sram_we_n), 32'd1);
            chk("rd_data", 32'(bus.Data_to_CPU), 32'(io ? sw : dq));
            chk("rd_dq_oe", 32'(sram_dq_oe), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_bus(1, 1, 1);
        bus.ADDR = '0;
        bus.Data_from_CPU = '0;
        switches = '0;
        sram_dq_in = '0;
        model_reset();
        do_reset();

        do_read(16'h0040, 16'hBEEF, 16'h1111, 2);

        do_write(16'h0123, 16'h1234);
        do_read(16'h0040, 16'h5A5A, 16'h2222, 1);
        chk("w1_cnt", 32'(wr_count), 32'd1);

        do_write(16'hFFFF, 16'h00A5);
        do_read(16'hFFFF, 16'hDEAD, 16'h0F0F, 1);
        chk_status("io");

        // Short write: Mem_WE low for one cycle only
        cyc();
        set_bus(0, 1, 0);
        bus.ADDR = 16'h0200;
        bus.Data_from_CPU = 16'h7777;
        cyc();
        set_bus(0, 1, 1);
        @(negedge clk);
        chk("sw_we_n", 32'(sram_we_n), 32'd1);
        cyc();
        set_bus(1, 1, 1);
        m_err = 1'b1;
        @(negedge clk);
        chk_status("sw");
        do_write(16'h0300, 16'hCAFE);

        // OE and WE low together
        do_reset();
        cyc();
        set_bus(0, 0, 0);
        bus.ADDR = 16'h0044;
        @(negedge clk);
        chk("cf_oe_n", 32'(sram_oe_n), 32'd1);
        chk("cf_we_n", 32'(sram_we_n), 32'd1);
        chk("cf_dq_oe", 32'(sram_dq_oe), 32'd0);
        cyc();
        set_bus(1, 1, 1);
        m_err = 1'b1;
        @(negedge clk);
        chk_status("cf");

        // Read attempted during the hold cycle of a write
        do_reset();
        cyc();
        set_bus(0, 1, 0);
        bus.ADDR = 16'h0555;
        bus.Data_from_CPU = 16'h4321;
        cyc();
        cyc();
        set_bus(0, 0, 1);
        sram_dq_in = 16'h9999;
        @(negedge clk);
        chk("rh_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rh_data", 32'(bus.Data_to_CPU), 32'd0);
        m_cnt = m_cnt + 16'd1;
        cyc();
        set_bus(1, 1, 1);
        m_err = 1'b1;
        @(negedge clk);
        chk_status("rh");

        // Mem_WE held low for four cycles triggers exactly one write
        do_reset();
        cyc();
        set_bus(0, 1, 0);
        bus.ADDR = 16'h0777;
        bus.Data_from_CPU = 16'h0101;
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("lw_we_n", 32'(sram_we_n), 32'd1);
        chk("lw_dq_oe", 32'(sram_dq_oe), 32'd0);
        m_cnt = m_cnt + 16'd1;
        cyc();
        set_bus(1, 1, 1);
        @(negedge clk);
        chk_status("lw");

        // Reset landing in the pulse cycle
        do_write(16'hFFFF, 16'h3C3C);
        cyc();
        set_bus(0, 1, 0);
        bus.ADDR = 16'h0010;
        bus.Data_from_CPU = 16'hABCD;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_bus(1, 1, 1);
        model_reset();
        @(negedge clk);
        chk("rp_we_n", 32'(sram_we_n), 32'd1);
        chk("rp_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk_status("rp");

        for (int k = 0; k < 24; k++) begin
            logic [15:0] a;
            logic [15:0] d;
            int          kind;
            kind = int'($urandom_range(0, 3));
            a = 16'($urandom);
            d = 16'($urandom);
            if (a == 16'hFFFF) a = 16'h0000;
            case (kind)
                0: do_write(a, d);
                1: do_write(16'hFFFF, d);
                2: do_read(a, d, 16'($urandom), 1);
                default: do_read(16'hFFFF, 16'($urandom), d, 1);
            endcase
        end
        cyc();
        set_bus(1, 1, 1);
        @(negedge clk);
        chk_status("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
